mips_mem_loader: RTL and testbench
==================================

// Module: mips_mem_loader
// PURPOSE
//  Byte-stream program/data loader: the write-side counterpart of the end-of-run
//  register/memory dump. Sits between an external byte source (bench or UART
//  receiver) and the write ports of instruction and data memory.
//  Holds the core stalled while loading, then releases it on command.
//  Assembles big-endian 32-bit words and writes them at consecutive word addresses.
// PARAMETERS
//  ADDR_W   8   word-address width of both memories (start address is one byte, zero-extended/truncated)
//  CNT_W    16  width of the word-count field (sent as 2 bytes, MSB first)
// PORTS
//  clock      in   1       rising-edge clock
//  reset      in   1       asynchronous, active-high
//  in_data    in   8       stream byte
//  in_valid   in   1       in_data valid
//  in_ready   out  1       loader can accept a byte this cycle
//  imem_we    out  1       instruction-memory write enable
//  dmem_we    out  1       data-memory write enable
//  mem_addr   out  ADDR_W  word address for the active write enable
//  mem_wdata  out  32      assembled word
//  core_hold  out  1       1 = core stalled (PC/regs must not update)
//  busy       out  1       frame in progress (state != IDLE)
//  load_done  out  1       1-cycle pulse with the last word's write
//  bad_cmd    out  1       1-cycle pulse: unknown command byte consumed
// BEHAVIOUR
//  Reset values: in_ready=1, imem_we=dmem_we=0, mem_addr=0, mem_wdata=0,
//   core_hold=1, busy=0, load_done=0, bad_cmd=0, state=IDLE. All outputs registered.
//  Byte accepted on a rising edge where in_valid & in_ready.
//  Frame: CMD, ADDR, CNT_H, CNT_L, then 4*count data bytes (MSB first per word).
//   CMD 0x49 'I' -> target imem; 0x44 'D' -> target dmem; 0x52 'R' -> run.
//  FSM: IDLE -> ADDR -> CNT_H -> CNT_L -> DATA -> IDLE.
//   IDLE, 'I'/'D': latch target, set core_hold=1, go ADDR.
//   IDLE, 'R': core_hold<=0, stay IDLE (no other bytes belong to the frame).
//   IDLE, other byte: consumed, bad_cmd pulses next cycle, stay IDLE, core_hold unchanged.
//   ADDR: mem_addr<=byte[ADDR_W-1:0]. CNT_H/CNT_L: load count.
//   CNT_L with count==0: return IDLE, no writes, load_done pulses anyway.
//   DATA: shift bytes into word; byte index 0..3 counter.
//  Write: on edge accepting the 4th byte, mem_wdata<=word, target we<=1 for exactly
//   one cycle; memory captures on the following edge. in_ready=0 during that cycle.
//  After each write cycle mem_addr increments by 1, wrapping 2^ADDR_W-1 -> 0;
//   remaining count decrements; at 0 the state is IDLE and load_done is high
//   in the same cycle as the final we.
//  Exactly one of imem_we/dmem_we may be high; never both.
//  Max throughput: 4 data bytes per 5 cycles (one stall cycle per word).
//  Reset mid-frame: partial word discarded, no write issued, all outputs to reset
//   values (core_hold=1), next byte parsed as CMD.
//  A new 'I'/'D' frame after 'R' re-asserts core_hold on acceptance of CMD.
//  in_valid low mid-frame: FSM waits indefinitely, no timeout.
// TESTING
//  1. Reset, send 49 00 00 02 20 08 00 05 20 09 00 07 -> imem_we at addr 0 data
//     32'h20080005, then addr 1 data 32'h20090007; load_done with 2nd write; core_hold=1.
//  2. Send 44 FF 00 02 + 8 bytes -> dmem_we at addr 8'hFF then 8'h00 (wrap); imem_we stays 0.
//  3. Send 52 -> core_hold falls the cycle after acceptance; busy stays 0.
//  4. Send 7A -> bad_cmd one-cycle pulse; no we; next 49 00 00 01 + 4 bytes loads normally.
//  5. Send 49 10 00 00 -> no write, load_done pulse, returns IDLE.
//  6. Assert reset after 2 of 4 data bytes -> no we, core_hold=1; resent frame writes
//     the full word at the frame's start address; in_ready low only in write cycles.

Source files
------------

// File: rtl/mips_mem_loader.sv
// rtl/mips_mem_loader.sv - byte-stream program/data loader for instruction and data memory
//
// Purpose: parses frames of CMD, ADDR, CNT_H, CNT_L and 4*count data bytes from a
// byte stream. It assembles big-endian 32-bit words and writes them to imem or dmem
// at consecutive word addresses. It holds the core stalled until an 'R' command arrives.
//
// Ports:
//   clock, reset         rising-edge clock, asynchronous active-high reset
//   in_data/in_valid     stream byte and its qualifier
//   in_ready             byte accepted on an edge where in_valid & in_ready
//   imem_we/dmem_we      one-cycle write strobes (never both high)
//   mem_addr/mem_wdata   word address and assembled word for the active strobe
//   core_hold            1 = core stalled
//   busy                 frame in progress
//   load_done            pulses with the final write, or alone for a zero-count frame
//   bad_cmd              pulses after an unknown command byte is consumed
module mips_mem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_hold,
  output logic              busy,
  output logic              load_done,
  output logic              bad_cmd
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT_H,
    S_CNT_L,
    S_DATA
  } state_t;

  localparam logic [7:0] CMD_IMEM = 8'h49;
  localparam logic [7:0] CMD_DMEM = 8'h44;
  localparam logic [7:0] CMD_RUN  = 8'h52;

  state_t              state_q, state_d;
  logic                tgt_dmem_q, tgt_dmem_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          idx_q, idx_d;
  logic [23:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                imem_we_q, imem_we_d;
  logic                dmem_we_q, dmem_we_d;
  logic                hold_q, hold_d;
  logic                done_q, done_d;
  logic                bad_q, bad_d;
  logic                ready_q, ready_d;
  logic                accept;
  logic [CNT_W-1:0]    cnt_full;

  assign accept   = in_valid & ready_q;
  assign cnt_full = cnt_q | CNT_W'(in_data);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_dmem_q <= 1'b0;
      cnt_q      <= '0;
      idx_q      <= '0;
      word_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      imem_we_q  <= 1'b0;
      dmem_we_q  <= 1'b0;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      bad_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      tgt_dmem_q <= tgt_dmem_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      imem_we_q  <= imem_we_d;
      dmem_we_q  <= dmem_we_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      bad_q      <= bad_d;
      ready_q    <= ready_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tgt_dmem_d = tgt_dmem_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    word_d     = word_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    imem_we_d  = 1'b0;
    dmem_we_d  = 1'b0;
    hold_d     = hold_q;
    done_d     = 1'b0;
    bad_d      = 1'b0;
    ready_d    = 1'b1;

    // The address advances as the memory captures the current word.
    if (imem_we_q || dmem_we_q) begin
      addr_d = addr_q + 1'b1;
    end

    if (accept) begin
      unique case (state_q)
        S_IDLE: begin
          if (in_data == CMD_IMEM || in_data == CMD_DMEM) begin
            tgt_dmem_d = (in_data == CMD_DMEM);
            hold_d     = 1'b1;
            state_d    = S_ADDR;
          end else if (in_data == CMD_RUN) begin
            hold_d = 1'b0;
          end else begin
            bad_d = 1'b1;
          end
        end
        S_ADDR: begin
          addr_d  = ADDR_W'(in_data);
          state_d = S_CNT_H;
        end
        S_CNT_H: begin
          cnt_d   = CNT_W'({in_data, 8'h00});
          state_d = S_CNT_L;
        end
        S_CNT_L: begin
          cnt_d = cnt_full;
          idx_d = '0;
          if (cnt_full == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          idx_d  = idx_q + 1'b1;
          word_d = {word_q[15:0], in_data};
          if (idx_q == 2'd3) begin
            wdata_d   = {word_q, in_data};
            imem_we_d = ~tgt_dmem_q;
            dmem_we_d = tgt_dmem_q;
            // Stall one cycle so the address increment lands before the next word.
            ready_d   = 1'b0;
            cnt_d     = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign in_ready  = ready_q;
  assign imem_we   = imem_we_q;
  assign dmem_we   = dmem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign core_hold = hold_q;
  assign busy      = (state_q != S_IDLE);
  assign load_done = done_q;
  assign bad_cmd   = bad_q;

endmodule

// File: tb/tb_mips_mem_loader.sv
// tb/tb_mips_mem_loader.sv - self-checking bench for mips_mem_loader
module tb_mips_mem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic        dmem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        core_hold;
  logic        busy;
  logic        load_done;
  logic        bad_cmd;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        tgt_dmem;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];

  mips_mem_loader #(.ADDR_W(8), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .dmem_we   (dmem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .busy      (busy),
    .load_done (load_done),
    .bad_cmd   (bad_cmd)
  );

  always #5 clock = ~clock;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (!reset) begin
      n_cmp++;
      if (in_ready !== !(imem_we | dmem_we)) begin
        n_err++;
        $display("FAIL in_ready_vs_we: in_ready=%b imem_we=%b dmem_we=%b, required in_ready low only in write cycles",
                 in_ready, imem_we, dmem_we);
      end
      if (imem_we === 1'b1 || dmem_we === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: imem_we=%b dmem_we=%b addr=%h data=%h, required no write",
                   imem_we, dmem_we, mem_addr, mem_wdata);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (imem_we !== !e.tgt_dmem || dmem_we !== e.tgt_dmem || mem_addr !== e.addr ||
              mem_wdata !== e.data || load_done !== e.last) begin
            n_err++;
            $display("FAIL write: got i=%b d=%b addr=%h data=%h done=%b, required i=%b d=%b addr=%h data=%h done=%b",
                     imem_we, dmem_we, mem_addr, mem_wdata, load_done,
                     !e.tgt_dmem, e.tgt_dmem, e.addr, e.data, e.last);
          end
        end
      end
    end
  end

  function automatic void push_exp(input logic d, input logic [7:0] a, input logic [31:0] w, input logic l);
    exp_t e;
    e.tgt_dmem = d;
    e.addr     = a;
    e.data     = w;
    e.last     = l;
    sb.push_back(e);
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (in_ready !== 1'b1 && t < 20) begin
      @(negedge clock);
      t++;
    end
    n_cmp++;
    if (t >= 20) begin
      n_err++;
      $display("FAIL send_timeout: in_ready=%b byte=%h, required in_ready=1 within 20 cycles", in_ready, b);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 20) begin
      @(negedge clock);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: pending writes=%0d, required 0", name, sb.size());
    end
  endtask

  task automatic send_words(input logic [31:0] w[$]);
    foreach (w[i]) begin
      send_byte(w[i][31:24]);
      send_byte(w[i][23:16]);
      send_byte(w[i][15:8]);
      send_byte(w[i][7:0]);
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if ({in_ready, imem_we, dmem_we, mem_addr, mem_wdata, core_hold, busy, load_done, bad_cmd} !==
        {1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b i=%b d=%b addr=%h data=%h hold=%b busy=%b done=%b bad=%b, required 1 0 0 00 00000000 1 0 0 0",
               in_ready, imem_we, dmem_we, mem_addr, mem_wdata, core_hold, busy, load_done, bad_cmd);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_imem_load();
    logic [31:0] w[$];
    w = '{32'h20080005, 32'h20090007};
    push_exp(1'b0, 8'h00, 32'h20080005, 1'b0);
    push_exp(1'b0, 8'h01, 32'h20090007, 1'b1);
    send_byte(8'h49);
    n_cmp++;
    if (busy !== 1'b1 || core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL imem_busy: busy=%b hold=%b, required 1 1", busy, core_hold);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    send_words(w);
    idle(1);
    drain("imem");
    n_cmp++;
    if (core_hold !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL imem_end: hold=%b busy=%b, required 1 0", core_hold, busy);
    end
  endtask

  task automatic test_dmem_wrap();
    logic [31:0] w[$];
    w = '{32'hDEADBEEF, 32'h01234567};
    push_exp(1'b1, 8'hFF, 32'hDEADBEEF, 1'b0);
    push_exp(1'b1, 8'h00, 32'h01234567, 1'b1);
    send_byte(8'h44); send_byte(8'hFF); send_byte(8'h00); send_byte(8'h02);
    send_words(w);
    idle(1);
    drain("dmem_wrap");
  endtask

  task automatic test_run();
    n_cmp++;
    if (core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL run_pre_hold: hold=%b, required 1", core_hold);
    end
    send_byte(8'h52);
    n_cmp++;
    if (core_hold !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL run_release: hold=%b busy=%b, required 0 0", core_hold, busy);
    end
    idle(1);
  endtask

  task automatic test_bad_cmd();
    logic [31:0] w[$];
    send_byte(8'h7A);
    n_cmp++;
    if (bad_cmd !== 1'b1 || busy !== 1'b0 || core_hold !== 1'b0) begin
      n_err++;
      $display("FAIL bad_cmd_pulse: bad=%b busy=%b hold=%b, required 1 0 0", bad_cmd, busy, core_hold);
    end
    idle(1);
    n_cmp++;
    if (bad_cmd !== 1'b0) begin
      n_err++;
      $display("FAIL bad_cmd_width: bad=%b, required 0", bad_cmd);
    end
    w = '{32'hCAFEF00D};
    push_exp(1'b0, 8'h00, 32'hCAFEF00D, 1'b1);
    send_byte(8'h49);
    n_cmp++;
    if (core_hold !== 1'b1) begin
      n_err++;
      $display("FAIL rehold: hold=%b, required 1", core_hold);
    end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
    send_words(w);
    idle(1);
    drain("after_bad");
  endtask

  task automatic test_zero_count();
    send_byte(8'h49); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
    n_cmp++;
    if (load_done !== 1'b1 || busy !== 1'b0 || imem_we !== 1'b0 || dmem_we !== 1'b0) begin
      n_err++;
      $display("FAIL zero_count: done=%b busy=%b i=%b d=%b, required 1 0 0 0", load_done, busy, imem_we, dmem_we);
    end
    idle(1);
    n_cmp++;
    if (load_done !== 1'b0) begin
      n_err++;
      $display("FAIL zero_count_width: done=%b, required 0", load_done);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] w[$];
    send_byte(8'h52);
    send_byte(8'h49); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'hA1); send_byte(8'hB2);
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (core_hold !== 1'b1 || busy !== 1'b0 || mem_addr !== 8'h00 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL mid_reset: hold=%b busy=%b addr=%h rdy=%b, required 1 0 00 1", core_hold, busy, mem_addr, in_ready);
    end
    w = '{32'hA1B2C3D4};
    push_exp(1'b0, 8'h20, 32'hA1B2C3D4, 1'b1);
    send_byte(8'h49); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    send_words(w);
    idle(1);
    drain("mid_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[$];
    int start, stop;
    w = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    push_exp(1'b1, 8'h40, 32'h11223344, 1'b0);
    push_exp(1'b1, 8'h41, 32'h55667788, 1'b0);
    push_exp(1'b1, 8'h42, 32'h99AABBCC, 1'b1);
    send_byte(8'h44); send_byte(8'h40); send_byte(8'h00); send_byte(8'h03);
    start = $time / 10;
    send_words(w);
    stop = $time / 10;
    idle(1);
    drain("b2b");
    // 12 data bytes with one stall after each of the first two words.
    n_cmp++;
    if (stop - start !== 14) begin
      n_err++;
      $display("FAIL b2b_cycles: got %0d cycles, required 14", stop - start);
    end
  endtask

  initial begin
    test_reset();
    test_imem_load();
    test_dmem_wrap();
    test_run();
    test_bad_cmd();
    test_zero_count();
    test_reset_mid_frame();
    test_back_to_back();
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
